// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson ring phase monitor.
package johnson_pkg;

  localparam int JOHNSON_PHASES = 10;
  localparam int JOHNSON_W      = 5;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACKING = 2'd1,
    LOCKED   = 2'd2
  } jmon_state_t;

  // Entry i is the ring pattern {a,b,c,d,e} of phase i.
  localparam logic [JOHNSON_PHASES-1:0][JOHNSON_W-1:0] JOHNSON_PATTERNS = {
    5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
    5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000
  };

  function automatic logic [3:0] next_phase(input logic [3:0] p);
    return (p == 4'(JOHNSON_PHASES - 1)) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decoder: ring pattern -> phase index, one-hot phase, validity.
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [JOHNSON_W-1:0]      pattern,
  output logic [3:0]                phase,
  output logic [JOHNSON_PHASES-1:0] phase_oh,
  output logic                      valid
);

  always_comb begin
    phase    = '0;
    phase_oh = '0;
    valid    = 1'b0;
    for (int i = 0; i < JOHNSON_PHASES; i++) begin
      if (pattern == JOHNSON_PATTERNS[i]) begin
        phase       = 4'(i);
        phase_oh[i] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson ring phase monitor: 2-stage decode, successor check and lock FSM.
// Define JOHNSON_MON_ERR_CNT_EN to add the saturating err_count port.
module johnson_phase_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
`ifdef JOHNSON_MON_ERR_CNT_EN
  output logic [ERR_W-1:0] err_count,
`endif
  output logic [3:0]       phase,
  output logic [9:0]       phase_oh,
  output logic             phase_valid,
  output logic             locked,
  output logic             illegal,
  output logic             seq_err,
  output logic             resync_req
);
  import johnson_pkg::*;

  localparam int          STAGES   = 1;
  localparam logic [3:0]  LOCK_RUN = 4'(LOCK_CNT);

  if (LOCK_CNT < 2 || LOCK_CNT > 15 || ERR_W < 1) begin : g_param_chk
    $error("johnson_phase_monitor: LOCK_CNT must be 2..15 and ERR_W >= 1");
  end

  // r_vld_pipe[0]: ring_q holds a real sample; r_vld_pipe[1]: stage 2 has seen one.
  logic [STAGES:0]             r_vld_pipe;
  logic [JOHNSON_W-1:0]        r_ring_q;
  logic [3:0]                  r_prev_phase;
  logic [JOHNSON_PHASES-1:0]   r_phase_oh;
  logic                        r_prev_valid;
  logic                        r_illegal, r_seq_err, r_resync;
  jmon_state_t                 r_state, w_state_nxt;
  logic [3:0]                  r_run, w_run_nxt;

  logic [3:0]                  w_dec_phase;
  logic [JOHNSON_PHASES-1:0]   w_dec_oh;
  logic                        w_dec_valid;
  logic                        w_smp, w_succ, w_illegal, w_seq_err, w_resync;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_ring_q   <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_ring_q   <= {a, b, c, d, e};
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  johnson_decode u_dec (
    .pattern  (r_ring_q),
    .phase    (w_dec_phase),
    .phase_oh (w_dec_oh),
    .valid    (w_dec_valid)
  );

  assign w_smp  = r_vld_pipe[0];
  assign w_succ = w_dec_valid && r_prev_valid &&
                  (w_dec_phase == next_phase(r_prev_phase));

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_seq_err   = 1'b0;
    w_illegal   = w_smp && !w_dec_valid;
    // The very first sample has no predecessor, so an illegal one still requests resync.
    w_resync    = w_illegal && (r_prev_valid || !r_vld_pipe[1]);
    if (w_smp) begin
      unique case (r_state)
        UNLOCKED: begin
          if (w_dec_valid) begin
            w_state_nxt = TRACKING;
            w_run_nxt   = 4'd1;
          end
        end
        TRACKING: begin
          if (!w_dec_valid) begin
            w_state_nxt = UNLOCKED;
            w_run_nxt   = 4'd0;
          end else if (w_succ) begin
            w_run_nxt = r_run + 4'd1;
            if (r_run + 4'd1 == LOCK_RUN) w_state_nxt = LOCKED;
          end else begin
            w_run_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (!w_succ) begin
            w_seq_err = 1'b1;
            if (w_dec_valid) begin
              w_state_nxt = TRACKING;
              w_run_nxt   = 4'd1;
            end else begin
              w_state_nxt = UNLOCKED;
              w_run_nxt   = 4'd0;
            end
          end
        end
        default: begin
          w_state_nxt = UNLOCKED;
          w_run_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= UNLOCKED;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // The registered decode doubles as prev_phase/prev_valid for the next sample.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_prev_phase <= '0;
      r_phase_oh   <= '0;
      r_prev_valid <= 1'b0;
      r_illegal    <= 1'b0;
      r_seq_err    <= 1'b0;
      r_resync     <= 1'b0;
    end else begin
      if (w_smp) begin
        r_prev_phase <= w_dec_phase;
        r_phase_oh   <= w_dec_oh;
        r_prev_valid <= w_dec_valid;
      end
      r_illegal <= w_illegal;
      r_seq_err <= w_seq_err;
      r_resync  <= w_resync;
    end
  end

`ifdef JOHNSON_MON_ERR_CNT_EN
  logic [ERR_W-1:0] r_err_cnt;
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                          r_err_cnt <= '0;
    else if (w_seq_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
  end
  assign err_count = r_err_cnt;
`endif

  assign phase       = r_prev_phase;
  assign phase_oh    = r_phase_oh;
  assign phase_valid = r_prev_valid;
  assign locked      = (r_state == LOCKED);
  assign illegal     = r_illegal;
  assign seq_err     = r_seq_err;
  assign resync_req  = r_resync;

endmodule
